// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave front-end: synchronizes SCLK/SS_n/MOSI into clk, frames
// MSB-first words, flags short/overrun frames and echoes the last good word on MISO.
module spi_frame_ctrl #(
  parameter int unsigned WORD_W      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WORD_W-1:0]      rx_reg, tx_reg;
  logic                   ovr;

  // SS_n chain resets to 0 so a select held across reset never yields a fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_rise   <= 1'b0;
      ss_fall   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
      ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_d;
      ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_d;
    end
  end

  // Any SS_n edge takes priority over an SCLK edge in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_reg      <= '0;
      tx_reg      <= '0;
      ovr         <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            rx_reg  <= '0;
            tx_reg  <= data_out;
            ovr     <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else if (!ss_fall) begin
            if (sclk_rise) begin
              rx_reg  <= {rx_reg[WORD_W-2:0], mosi_sync[SYNC_STAGES-1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(WORD_W - 1))
                state <= DONE;
            end else if (sclk_fall) begin
              tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (ss_rise) begin
            state <= IDLE;
            ovr   <= 1'b0;
            if (ovr) begin
              frame_err <= 1'b1;
            end else begin
              data_out    <= rx_reg;
              data_valid  <= 1'b1;
              frame_count <= frame_count + 1'b1;
              frame_err   <= 1'b0;
            end
          end else if (!ss_fall && sclk_rise) begin
            ovr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    MISO = 1'b0;
    if (state != IDLE && !ss_sync[SYNC_STAGES-1])
      MISO = tx_reg[WORD_W-1];
  end

endmodule
